// File: rtl/mem_access_ctrl_pkg.sv
// Shared types and defaults for the memory access sequencer.
//   ADDR_W_DEF / DATA_W_DEF : default RAM word-address and data widths
//   CNT_W                   : wait-state counter width
//   mem_state_t             : sequencer FSM states
//   req_kind_t              : kind of a detected or pending request
package mem_access_ctrl_pkg;

  localparam int unsigned ADDR_W_DEF = 9;
  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned CNT_W      = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD      = 2'd1,
    WR      = 2'd2,
    WR_HOLD = 2'd3
  } mem_state_t;

  typedef enum logic [1:0] {
    REQ_NONE = 2'd0,
    REQ_RD   = 2'd1,
    REQ_WR   = 2'd2
  } req_kind_t;

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Bus bundle between control unit / RAM and the access sequencer.
//   slave  : sequencer side (takes strobes and RAM data, drives RAM and status)
//   master : control-unit / RAM side
interface mem_access_ctrl_if #(
  parameter int unsigned ADDR_W = 9,
  parameter int unsigned DATA_W = 32
);
  logic              Read_req;
  logic              Write_req;
  logic [ADDR_W-1:0] MAR_addr;
  logic [DATA_W-1:0] MDR_wdata;
  logic [DATA_W-1:0] Mem_rdata;
  logic [ADDR_W-1:0] Mem_addr;
  logic [DATA_W-1:0] Mem_wdata;
  logic              Mem_re;
  logic              Mem_we;
  logic [DATA_W-1:0] Rdata;
  logic              Rdata_valid;
  logic              Busy;
  logic              Done;
  logic              Err;

  modport slave (
    input  Read_req, Write_req, MAR_addr, MDR_wdata, Mem_rdata,
    output Mem_addr, Mem_wdata, Mem_re, Mem_we, Rdata, Rdata_valid, Busy, Done, Err
  );

  modport master (
    output Read_req, Write_req, MAR_addr, MDR_wdata, Mem_rdata,
    input  Mem_addr, Mem_wdata, Mem_re, Mem_we, Rdata, Rdata_valid, Busy, Done, Err
  );
endinterface

// File: rtl/mem_access_ctrl_req_tracker.sv
// Request edge detection, simultaneous-request check and one-deep pending slot.
//   clk, rst_n         : clock, async active-low reset
//   rd_req_i, wr_req_i : level strobes from the control unit
//   addr_i, data_i     : MAR address / MDR write data
//   take_i             : sequencer accepts the offered request this edge
//   req_*_c            : offered request (pending slot first, else a fresh edge)
//   err_o              : one-cycle pulse for a collision or a slot overflow
module mem_access_ctrl_req_tracker
  import mem_access_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rd_req_i,
  input  logic              wr_req_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              take_i,
  output req_kind_t         req_kind_c,
  output logic [ADDR_W-1:0] req_addr_c,
  output logic [DATA_W-1:0] req_data_c,
  output logic              err_o
);

  logic              rd_prev_q, wr_prev_q;
  logic              full_q, full_d;
  req_kind_t         kind_q, kind_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              err_q, err_d;
  logic              rd_edge, wr_edge;
  req_kind_t         new_kind;

  // Edge classification and request offered to the sequencer
  always_comb begin
    rd_edge  = rd_req_i & ~rd_prev_q;
    wr_edge  = wr_req_i & ~wr_prev_q;
    new_kind = REQ_NONE;
    if (rd_edge && !wr_edge) new_kind = REQ_RD;
    if (wr_edge && !rd_edge) new_kind = REQ_WR;
    req_kind_c = full_q ? kind_q : new_kind;
    req_addr_c = full_q ? addr_q : addr_i;
    req_data_c = full_q ? data_q : data_i;
  end

  // Pending slot update; a fresh edge refills a slot that is drained this edge
  always_comb begin
    full_d = full_q;
    kind_d = kind_q;
    addr_d = addr_q;
    data_d = data_q;
    err_d  = rd_edge & wr_edge;
    if (take_i && full_q) begin
      full_d = (new_kind != REQ_NONE);
      kind_d = new_kind;
      addr_d = addr_i;
      data_d = data_i;
    end else if (!take_i && new_kind != REQ_NONE) begin
      if (full_q) begin
        err_d = 1'b1;
      end else begin
        full_d = 1'b1;
        kind_d = new_kind;
        addr_d = addr_i;
        data_d = data_i;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_prev_q <= 1'b0;
      wr_prev_q <= 1'b0;
      full_q    <= 1'b0;
      kind_q    <= REQ_NONE;
      addr_q    <= '0;
      data_q    <= '0;
      err_q     <= 1'b0;
    end else begin
      rd_prev_q <= rd_req_i;
      wr_prev_q <= wr_req_i;
      full_q    <= full_d;
      kind_q    <= kind_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      err_q     <= err_d;
    end
  end

  assign err_o = err_q;

endmodule

// File: rtl/mem_access_ctrl.sv
// Multi-cycle sequencer turning level read/write strobes into single timed RAM accesses.
//   Clock : system clock, rising edge
//   Reset : asynchronous active-low reset
//   bus   : strobes, MAR/MDR, RAM interface, Rdata/Rdata_valid, Busy/Done/Err
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W  = ADDR_W_DEF,
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned RD_WAIT = 1,
  parameter int unsigned WR_WAIT = 1
) (
  input logic               Clock,
  input logic               Reset,
  mem_access_ctrl_if.slave  bus
);

  mem_state_t        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              rdata_valid_q, rdata_valid_d;
  logic              mem_re_q, mem_re_d;
  logic              mem_we_q, mem_we_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              take_c;
  logic              err;
  req_kind_t         req_kind_c;
  logic [ADDR_W-1:0] req_addr_c;
  logic [DATA_W-1:0] req_data_c;

  mem_access_ctrl_req_tracker #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_tracker (
    .clk        (Clock),
    .rst_n      (Reset),
    .rd_req_i   (bus.Read_req),
    .wr_req_i   (bus.Write_req),
    .addr_i     (bus.MAR_addr),
    .data_i     (bus.MDR_wdata),
    .take_i     (take_c),
    .req_kind_c (req_kind_c),
    .req_addr_c (req_addr_c),
    .req_data_c (req_data_c),
    .err_o      (err)
  );

  assign take_c = (state_q == IDLE) && (req_kind_c != REQ_NONE);

  // State register
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state; the counter is loaded once at request start and only counts down
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (take_c) begin
          state_d = (req_kind_c == REQ_RD) ? RD : WR;
          cnt_d   = (req_kind_c == REQ_RD) ? CNT_W'(RD_WAIT) : CNT_W'(WR_WAIT);
        end
      end
      RD, WR_HOLD: begin
        if (cnt_q == '0) state_d = IDLE;
        else             cnt_d   = CNT_W'(cnt_q - 1'b1);
      end
      WR: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          state_d = WR_HOLD;
          cnt_d   = CNT_W'(cnt_q - 1'b1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output next values, registered below so strobes line up with the state they belong to
  always_comb begin
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    rdata_d       = rdata_q;
    rdata_valid_d = rdata_valid_q;
    done_d        = 1'b0;
    mem_re_d      = (state_d == RD);
    mem_we_d      = (state_d == WR);
    busy_d        = (state_d != IDLE);
    if (take_c) begin
      mem_addr_d = req_addr_c;
      if (req_kind_c == REQ_WR) mem_wdata_d   = req_data_c;
      if (req_kind_c == REQ_RD) rdata_valid_d = 1'b0;
    end
    if (state_q == RD && cnt_q == '0) begin
      rdata_d       = bus.Mem_rdata;
      rdata_valid_d = 1'b1;
      done_d        = 1'b1;
    end
    if ((state_q == WR || state_q == WR_HOLD) && cnt_q == '0) done_d = 1'b1;
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      rdata_q       <= '0;
      rdata_valid_q <= 1'b0;
      mem_re_q      <= 1'b0;
      mem_we_q      <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      rdata_q       <= rdata_d;
      rdata_valid_q <= rdata_valid_d;
      mem_re_q      <= mem_re_d;
      mem_we_q      <= mem_we_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  assign bus.Mem_addr    = mem_addr_q;
  assign bus.Mem_wdata   = mem_wdata_q;
  assign bus.Mem_re      = mem_re_q;
  assign bus.Mem_we      = mem_we_q;
  assign bus.Rdata       = rdata_q;
  assign bus.Rdata_valid = rdata_valid_q;
  assign bus.Busy        = busy_q;
  assign bus.Done        = done_q;
  assign bus.Err         = err;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl with a behavioural sync RAM and a
// transaction-level reference memory.
module tb_mem_access_ctrl;

  localparam int unsigned RD_WAIT = 1;
  localparam int unsigned WR_WAIT = 2;

  logic clk;
  logic rst_n;
  logic ram_clr;

  mem_access_ctrl_if #(.ADDR_W(9), .DATA_W(32)) bus();

  mem_access_ctrl #(
    .ADDR_W (9),
    .DATA_W (32),
    .RD_WAIT(RD_WAIT),
    .WR_WAIT(WR_WAIT)
  ) dut (
    .Clock (clk),
    .Reset (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural 512x32 RAM with one-cycle read latency
  logic [31:0] ram [512];
  logic        written [512];
  logic [31:0] ram_rdata;

  function automatic logic [31:0] init_word(input int a);
    return (a == 5) ? 32'h1234_ABCD : (32'hA5A5_0000 | 32'(a));
  endfunction

  always @(posedge clk) begin
    if (ram_clr) begin
      for (int i = 0; i < 512; i++) written[i] <= 1'b0;
    end else begin
      if (bus.Mem_we) begin
        ram[bus.Mem_addr]     <= bus.Mem_wdata;
        written[bus.Mem_addr] <= 1'b1;
      end
      if (bus.Mem_re)
        ram_rdata <= written[bus.Mem_addr] ? ram[bus.Mem_addr] : init_word(int'(bus.Mem_addr));
    end
  end
  assign bus.Mem_rdata = ram_rdata;

  logic [31:0] ref_mem [512];

  int n_chk, n_fail;
  int re_cnt, we_cnt, done_cnt, err_cnt, busy_cnt, overlap, sidx, first_re, first_done;
  logic [8:0]  re_addr, we_addr;
  logic [31:0] we_data;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clr();
    re_cnt = 0; we_cnt = 0; done_cnt = 0; err_cnt = 0; busy_cnt = 0; overlap = 0;
    sidx = 0; first_re = -1; first_done = -1;
    re_addr = '0; we_addr = '0; we_data = '0;
  endtask

  // One clock, then sample 1ns after the edge and accumulate activity
  task automatic step();
    @(posedge clk);
    #1;
    if (bus.Mem_re) begin
      re_cnt++; re_addr = bus.Mem_addr;
      if (first_re < 0) first_re = sidx;
    end
    if (bus.Mem_we) begin
      we_cnt++; we_addr = bus.Mem_addr; we_data = bus.Mem_wdata;
    end
    if (bus.Done) begin
      done_cnt++;
      if (first_done < 0) first_done = sidx;
    end
    if (bus.Err)  err_cnt++;
    if (bus.Busy) busy_cnt++;
    if (bus.Done && bus.Busy) overlap++;
    sidx++;
  endtask

  // Single isolated request held for 'hold' cycles, checked against the reference memory
  task automatic do_req(input bit is_wr, input logic [8:0] a, input logic [31:0] d, input int hold);
    clr();
    bus.MAR_addr  = a;
    bus.MDR_wdata = d;
    if (is_wr) bus.Write_req = 1'b1; else bus.Read_req = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      if (i == hold - 1) begin
        bus.Read_req  = 1'b0;
        bus.Write_req = 1'b0;
      end
    end
    chk("done_count", 32'(done_cnt), 32'd1);
    chk("err_count", 32'(err_cnt), 32'd0);
    chk("done_while_busy", 32'(overlap), 32'd0);
    if (is_wr) begin
      ref_mem[a] = d;
      chk("wr_we_cycles", 32'(we_cnt), 32'd1);
      chk("wr_re_cycles", 32'(re_cnt), 32'd0);
      chk("wr_addr", 32'(we_addr), 32'(a));
      chk("wr_data", we_data, d);
      chk("wr_busy_cycles", 32'(busy_cnt), WR_WAIT + 1);
    end else begin
      chk("rd_re_cycles", 32'(re_cnt), RD_WAIT + 1);
      chk("rd_we_cycles", 32'(we_cnt), 32'd0);
      chk("rd_addr", 32'(re_addr), 32'(a));
      chk("rd_busy_cycles", 32'(busy_cnt), RD_WAIT + 1);
      chk("rd_data", bus.Rdata, ref_mem[a]);
      chk("rd_valid", 32'(bus.Rdata_valid), 32'd1);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"},  32'(bus.Busy), 32'd0);
    chk({tag, "_done"},  32'(bus.Done), 32'd0);
    chk({tag, "_err"},   32'(bus.Err), 32'd0);
    chk({tag, "_re"},    32'(bus.Mem_re), 32'd0);
    chk({tag, "_we"},    32'(bus.Mem_we), 32'd0);
    chk({tag, "_valid"}, 32'(bus.Rdata_valid), 32'd0);
    chk({tag, "_rdata"}, bus.Rdata, 32'd0);
    chk({tag, "_addr"},  32'(bus.Mem_addr), 32'd0);
    chk({tag, "_wdata"}, bus.Mem_wdata, 32'd0);
  endtask

  initial begin
    logic [31:0] rnd_data;
    n_chk = 0; n_fail = 0;
    for (int i = 0; i < 512; i++) ref_mem[i] = init_word(i);
    bus.Read_req = 1'b0; bus.Write_req = 1'b0; bus.MAR_addr = '0; bus.MDR_wdata = '0;
    rst_n = 1'b0; ram_clr = 1'b1;
    clr();
    repeat (3) step();
    chk_all_zero("reset");
    rst_n = 1'b1; ram_clr = 1'b0;
    step();

    // Read 0x05 held 4 cycles: one access only
    do_req(1'b0, 9'h005, 32'h0, 4);
    chk("rd05_data", bus.Rdata, 32'h1234_ABCD);

    // Write 0x1F, then read it back
    do_req(1'b1, 9'h01F, 32'hDEAD_BEEF, 2);
    do_req(1'b0, 9'h01F, 32'h0, 1);

    // Simultaneous read and write edges
    clr();
    bus.MAR_addr = 9'h010; bus.Read_req = 1'b1; bus.Write_req = 1'b1;
    step();
    chk("coll_err_pulse", 32'(bus.Err), 32'd1);
    for (int i = 0; i < 6; i++) begin
      step();
      if (i == 2) begin bus.Read_req = 1'b0; bus.Write_req = 1'b0; end
    end
    chk("coll_err_count", 32'(err_cnt), 32'd1);
    chk("coll_re", 32'(re_cnt), 32'd0);
    chk("coll_we", 32'(we_cnt), 32'd0);
    chk("coll_busy", 32'(busy_cnt), 32'd0);
    chk("coll_done", 32'(done_cnt), 32'd0);

    // Write 0x02, read 0x02 arriving during the write hold
    clr();
    bus.MAR_addr = 9'h002; bus.MDR_wdata = 32'hCAFE_0002; bus.Write_req = 1'b1;
    step(); step();
    ref_mem[2] = 32'hCAFE_0002;
    bus.Write_req = 1'b0; bus.Read_req = 1'b1;
    for (int i = 0; i < 18; i++) begin
      step();
      if (i == 1) bus.Read_req = 1'b0;
    end
    chk("wrrd_done", 32'(done_cnt), 32'd2);
    chk("wrrd_err", 32'(err_cnt), 32'd0);
    chk("wrrd_we_addr", 32'(we_addr), 32'h2);
    chk("wrrd_re_addr", 32'(re_addr), 32'h2);
    chk("wrrd_no_gap", 32'(first_re), 32'(first_done + 1));
    chk("wrrd_data", bus.Rdata, ref_mem[2]);

    // Three edges while busy: second pending, third dropped with Err
    clr();
    bus.MAR_addr = 9'h030; bus.MDR_wdata = 32'h3030_3030; bus.Write_req = 1'b1;
    step();
    ref_mem[9'h030] = 32'h3030_3030;
    bus.Write_req = 1'b0; bus.Read_req = 1'b1; bus.MAR_addr = 9'h005;
    step();
    bus.Read_req = 1'b0;
    step();
    bus.Read_req = 1'b1; bus.MAR_addr = 9'h006;
    step();
    bus.Read_req = 1'b0;
    for (int i = 0; i < 16; i++) step();
    chk("three_done", 32'(done_cnt), 32'd2);
    chk("three_err", 32'(err_cnt), 32'd1);
    chk("three_we", 32'(we_cnt), 32'd1);
    chk("three_re", 32'(re_cnt), RD_WAIT + 1);
    chk("three_re_addr", 32'(re_addr), 32'h5);
    chk("three_data", bus.Rdata, ref_mem[5]);

    // Reset mid-write while Mem_we is high
    clr();
    bus.MAR_addr = 9'h040; bus.MDR_wdata = 32'h4040_4040; bus.Write_req = 1'b1;
    step();
    chk("rstw_we_before", 32'(bus.Mem_we), 32'd1);
    #2 rst_n = 1'b0;
    #1 chk_all_zero("rst_async");
    clr();
    bus.Write_req = 1'b0;
    step(); step();
    chk("rstw_no_done", 32'(done_cnt), 32'd0);
    chk("rstw_no_we", 32'(we_cnt), 32'd0);
    #2 rst_n = 1'b1;
    step();
    do_req(1'b0, 9'h005, 32'h0, 2);

    // Randomized isolated transactions over a small address window
    for (int n = 0; n < 24; n++) begin
      rnd_data = $urandom;
      do_req(1'($urandom_range(0, 1)), 9'($urandom_range(0, 15)), rnd_data,
             int'($urandom_range(1, 5)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Multi-cycle memory sequencer between the control unit's memory strobes (MDR_read, RAM_write) and the synchronous 512x32 RAM.
- Converts level-held read/write requests into single, correctly timed RAM accesses with configurable wait states.
- Returns captured read data for the MDR, plus Busy/Done for stall handling.
- Guarantees exactly one RAM access per request, regardless of how long the control unit holds the strobe.

Parameters:
- ADDR_W, 9, RAM word-address width.
- DATA_W, 32, data width.
- RD_WAIT, 1, extra cycles Mem_re is held before read capture (legal 0..15).
- WR_WAIT, 1, extra Busy cycles after the Mem_we cycle (legal 0..15).

Ports:
- Clock  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-low reset.
- Read_req  in  1  level read request (driven from MDR_read).
- Write_req  in  1  level write request (driven from RAM_write).
- MAR_addr  in  ADDR_W  address from MAR.
- MDR_wdata  in  DATA_W  write data from MDR.
- Mem_rdata  in  DATA_W  RAM read data (1-cycle synchronous RAM).
- Mem_addr  out  ADDR_W  registered RAM address.
- Mem_wdata  out  DATA_W  registered RAM write data.
- Mem_re  out  1  RAM read enable.
- Mem_we  out  1  RAM write enable.
- Rdata  out  DATA_W  last captured read word, to MDR mux.
- Rdata_valid  out  1  Rdata holds the result of the most recent read.
- Busy  out  1  access in progress.
- Done  out  1  one-cycle completion pulse.
- Err  out  1  one-cycle protocol-error pulse.

Behaviour:
- Reset (Reset=0, asynchronous):
  - All outputs go to 0, Mem_we included, immediately.
  - FSM goes to IDLE; request history regs and the pending slot clear.
  - An access in flight is abandoned, with no Done.
- Request detection:
  - A request is a rising edge of Read_req or Write_req: sampled 1 now, 0 on the previous edge.
  - Holding the level high never retriggers.
- Simultaneous read and write edges: Err pulses for 1 cycle, both are dropped, no access occurs.
- FSM states: IDLE, RD, WR, WR_HOLD.
- IDLE:
  - On a request edge at clock edge T0, latch MAR_addr into Mem_addr (and MDR_wdata into Mem_wdata for writes), load the wait counter, set Busy.
  - Read goes to RD; Rdata_valid clears.
  - Write goes to WR.
- RD:
  - Mem_re=1 for RD_WAIT+1 cycles.
  - At edge T0+RD_WAIT+1, capture Mem_rdata into Rdata, set Rdata_valid, pulse Done, go to IDLE.
- WR:
  - Mem_we=1 for exactly one cycle (T0..T0+1).
  - If WR_WAIT=0, go to IDLE at T0+1 with Done; otherwise go to WR_HOLD.
- WR_HOLD:
  - Mem_we=0, Busy=1 for WR_WAIT cycles.
  - Then pulse Done and go to IDLE.
- Output timing:
  - Busy = (state != IDLE).
  - Done is asserted in the cycle after the completing edge; Busy is already 0 in that cycle.
- Pending slot (one-deep):
  - A request edge arriving while Busy is recorded with its address and data.
  - In IDLE, a pending request is serviced before any new edge, so back-to-back requests lose no cycle.
  - A second edge while the slot is full pulses Err and is dropped.
- Hold values:
  - Rdata holds its value until the next read capture.
  - Mem_addr and Mem_wdata hold their values between accesses.
- Counter width: 4 bits, decremented to 0, no wrap.

Decomposition:
- cpu_mem_pkg holds:
  - ADDR_W/DATA_W defaults.
  - mem_state_t enum {IDLE, RD, WR, WR_HOLD}.
  - A request-kind enum {REQ_NONE, REQ_RD, REQ_WR}.
- Sub-module mem_req_tracker: edge detection, the simultaneous-request check, and the one-deep pending slot (kind, address, data, full flag). It outputs the next request and Err to the FSM.

Test Plan:
- Read, RD_WAIT=1, RAM[0x05]=0x1234_ABCD:
  - Raise Read_req with MAR_addr=0x05 and hold it 4 cycles.
  - Mem_re is high 2 cycles; Rdata=0x1234_ABCD after T0+2; Done pulses once; no second Mem_re.
- Write, WR_WAIT=2, MAR_addr=0x1F, MDR_wdata=0xDEAD_BEEF:
  - Mem_we is high exactly 1 cycle with those values.
  - Busy is high 3 cycles; Done pulses once; a readback of 0x1F returns 0xDEAD_BEEF.
- Read_req and Write_req rise on the same edge:
  - Err pulses 1 cycle; Mem_re/Mem_we stay 0; Busy stays 0.
- Write to 0x02, then a read edge for 0x02 during WR_HOLD:
  - The read is serviced immediately after the write's Done.
  - It returns the new data; no Err.
- Three request edges in quick succession while Busy: the 2nd is pending and serviced; the 3rd produces an Err pulse and is dropped.
- Reset=0 asserted mid-write while Mem_we=1:
  - Mem_we drops without waiting for a clock; all outputs are 0; no Done.
  - After release, a new read completes normally.
